// File: rtl/mgmt_wb_splitter_pkg.sv
// Shared types and helpers for the management-core Wishbone splitter.
package mgmt_wb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic [31:0] WB_ERR_DATA = 32'hFFFF_FFFF;

   // Widest packed vector / slice the helper handles (8 channels x 64 bits)
   localparam int unsigned VEC_MAX   = 512;
   localparam int unsigned SLICE_MAX = 64;

   function automatic logic [SLICE_MAX-1:0] vec_slice(input logic [VEC_MAX-1:0] vec,
                                                      input int unsigned i,
                                                      input int unsigned w);
      logic [VEC_MAX-1:0] sh;
      sh = vec >> (i * w);
      return SLICE_MAX'(sh) & ((SLICE_MAX'(1) << w) - SLICE_MAX'(1));
   endfunction

endpackage

// File: rtl/mgmt_wb_splitter_if.sv
// Wishbone bus bundle: management-core master side plus the N_SLV slave channels.
interface mgmt_wb_splitter_if #(
   parameter int unsigned N_SLV = 2,
   parameter int unsigned AW    = 32,
   parameter int unsigned DW    = 32
);
   logic                m_cyc_i;
   logic                m_stb_i;
   logic                m_we_i;
   logic [DW/8-1:0]     m_sel_i;
   logic [AW-1:0]       m_adr_i;
   logic [DW-1:0]       m_dat_i;
   logic                m_ack_o;
   logic                m_err_o;
   logic [DW-1:0]       m_dat_o;
   logic [N_SLV-1:0]    s_cyc_o;
   logic [N_SLV-1:0]    s_stb_o;
   logic                s_we_o;
   logic [DW/8-1:0]     s_sel_o;
   logic [AW-1:0]       s_adr_o;
   logic [DW-1:0]       s_dat_o;
   logic [N_SLV-1:0]    s_ack_i;
   logic [N_SLV*DW-1:0] s_dat_i;
   logic [N_SLV-1:0]    s_iena_i;

   // Splitter's view
   modport slave (
      input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
             s_ack_i, s_dat_i, s_iena_i,
      output m_ack_o, m_err_o, m_dat_o,
             s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
   );

   // Environment's view (core and slave ports)
   modport master (
      output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
             s_ack_i, s_dat_i, s_iena_i,
      input  m_ack_o, m_err_o, m_dat_o,
             s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
   );
endinterface

// File: rtl/mgmt_wb_addr_decode.sv
// Combinational priority address decoder; lowest matching channel index wins.
module mgmt_wb_addr_decode #(
   parameter int unsigned          N_SLV    = 2,
   parameter int unsigned          AW       = 32,
   parameter logic [N_SLV*AW-1:0]  SLV_BASE = {32'h3000_0000, 32'h2600_0000},
   parameter logic [N_SLV*AW-1:0]  SLV_MASK = {32'hF000_0000, 32'hFF00_0000},
   localparam int unsigned         IW       = (N_SLV > 1) ? $clog2(N_SLV) : 1
) (
   input  logic [AW-1:0] adr,
   output logic          hit,
   output logic [IW-1:0] idx
);

   // Scan high to low so the lowest index overwrites any higher match
   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int i = N_SLV - 1; i >= 0; i--) begin
         if ((adr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
            hit = 1'b1;
            idx = IW'(i);
         end
      end
   end

endmodule

// File: rtl/mgmt_wb_splitter.sv
// Wishbone classic 1-to-N_SLV splitter with registered request/response paths.
// Optional REQ timeout enabled by defining MGMT_WB_SPLITTER_TIMEOUT_EN.
module mgmt_wb_splitter
   import mgmt_wb_pkg::*;
#(
   parameter int unsigned          N_SLV     = 2,
   parameter int unsigned          AW        = 32,
   parameter int unsigned          DW        = 32,
   parameter logic [N_SLV*AW-1:0]  SLV_BASE  = {32'h3000_0000, 32'h2600_0000},
   parameter logic [N_SLV*AW-1:0]  SLV_MASK  = {32'hF000_0000, 32'hFF00_0000},
   parameter int unsigned          TO_CYCLES = 255,
   parameter int unsigned          TO_W      = 8,
   localparam int unsigned         IW        = (N_SLV > 1) ? $clog2(N_SLV) : 1
) (
   input  logic                 core_clk,
   input  logic                 core_rst,
   mgmt_wb_splitter_if.slave    bus,
   output logic                 busy_o,
   output logic [AW-1:0]        err_adr_o
);

   state_e            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic              we_q, we_d;
   logic [DW/8-1:0]   sel_q, sel_d;
   logic [AW-1:0]     adr_q, adr_d;
   logic [DW-1:0]     wdat_q, wdat_d;
   logic [N_SLV-1:0]  stb_q, stb_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;
   logic [DW-1:0]     rdat_q, rdat_d;
   logic [AW-1:0]     err_adr_q, err_adr_d;

   logic              dec_hit;
   logic [IW-1:0]     dec_idx;
   logic              ack_ok;
   logic              to_hit;

   mgmt_wb_addr_decode #(
      .N_SLV    (N_SLV),
      .AW       (AW),
      .SLV_BASE (SLV_BASE),
      .SLV_MASK (SLV_MASK)
   ) u_dec (
      .adr (bus.m_adr_i),
      .hit (dec_hit),
      .idx (dec_idx)
   );

   // stb_q is one-hot on the selected channel while in REQ
   assign ack_ok = |(bus.s_ack_i & bus.s_iena_i & stb_q);

`ifdef MGMT_WB_SPLITTER_TIMEOUT_EN
   logic [TO_W-1:0] cnt_q, cnt_d;

   always_comb cnt_d = (state_q == REQ) ? cnt_q + 1'b1 : '0;
   assign to_hit = (state_q == REQ) && (cnt_q == TO_W'(TO_CYCLES));

   always_ff @(posedge core_clk) begin
      if (core_rst) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end
`else
   assign to_hit = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      we_d      = we_q;
      sel_d     = sel_q;
      adr_d     = adr_q;
      wdat_d    = wdat_q;
      stb_d     = stb_q;
      err_adr_d = err_adr_q;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      rdat_d    = '0;
      case (state_q)
         IDLE: begin
            if (bus.m_cyc_i && bus.m_stb_i) begin
               if (dec_hit) begin
                  idx_d   = dec_idx;
                  we_d    = bus.m_we_i;
                  sel_d   = bus.m_sel_i;
                  adr_d   = bus.m_adr_i;
                  wdat_d  = bus.m_dat_i;
                  stb_d   = N_SLV'(1) << dec_idx;
                  state_d = REQ;
               end else begin
                  err_d     = 1'b1;
                  rdat_d    = DW'(WB_ERR_DATA);
                  err_adr_d = bus.m_adr_i;
                  state_d   = RESP;
               end
            end
         end
         REQ: begin
            // Master abort beats a coincident ack: nobody is left to take it
            if (!bus.m_cyc_i) begin
               stb_d   = '0;
               state_d = IDLE;
            end else if (ack_ok) begin
               stb_d   = '0;
               ack_d   = 1'b1;
               rdat_d  = we_q ? '0 : DW'(vec_slice(VEC_MAX'(bus.s_dat_i), 32'(idx_q), DW));
               state_d = RESP;
            end else if (to_hit) begin
               stb_d     = '0;
               err_d     = 1'b1;
               rdat_d    = DW'(WB_ERR_DATA);
               err_adr_d = adr_q;
               state_d   = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge core_clk) begin
      if (core_rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         we_q      <= 1'b0;
         sel_q     <= '0;
         adr_q     <= '0;
         wdat_q    <= '0;
         stb_q     <= '0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         rdat_q    <= '0;
         err_adr_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         we_q      <= we_d;
         sel_q     <= sel_d;
         adr_q     <= adr_d;
         wdat_q    <= wdat_d;
         stb_q     <= stb_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         rdat_q    <= rdat_d;
         err_adr_q <= err_adr_d;
      end
   end

   assign bus.m_ack_o = ack_q;
   assign bus.m_err_o = err_q;
   assign bus.m_dat_o = rdat_q;
   assign bus.s_cyc_o = stb_q;
   assign bus.s_stb_o = stb_q;
   assign bus.s_we_o  = we_q;
   assign bus.s_sel_o = sel_q;
   assign bus.s_adr_o = adr_q;
   assign bus.s_dat_o = wdat_q;
   assign busy_o      = (state_q != IDLE);
   assign err_adr_o   = err_adr_q;

endmodule

// File: tb/tb_mgmt_wb_splitter.sv
// Directed bench for mgmt_wb_splitter: decode, gating, unmapped error, abort, reset, hang/timeout.
module tb_mgmt_wb_splitter;

   logic        core_clk = 1'b0;
   logic        core_rst;
   logic        busy_o;
   logic [31:0] err_adr_o;
   int          n_vec = 0;
   int          n_err = 0;
   int          first_err;

   always #5 core_clk = ~core_clk;

   mgmt_wb_splitter_if #(.N_SLV(2), .AW(32), .DW(32)) bus ();

   mgmt_wb_splitter #(
      .N_SLV     (2),
      .AW        (32),
      .DW        (32),
      .SLV_BASE  ({32'h3000_0000, 32'h2600_0000}),
      .SLV_MASK  ({32'hF000_0000, 32'hFF00_0000}),
      .TO_CYCLES (255),
      .TO_W      (8)
   ) dut (
      .core_clk  (core_clk),
      .core_rst  (core_rst),
      .bus       (bus),
      .busy_o    (busy_o),
      .err_adr_o (err_adr_o)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge core_clk);
      #1;
   endtask

   task automatic req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel);
      bus.m_cyc_i = 1'b1;
      bus.m_stb_i = 1'b1;
      bus.m_we_i  = we;
      bus.m_adr_i = adr;
      bus.m_dat_i = dat;
      bus.m_sel_i = sel;
   endtask

   task automatic drop();
      bus.m_cyc_i = 1'b0;
      bus.m_stb_i = 1'b0;
      bus.s_ack_i = 2'b00;
   endtask

   initial begin
      core_rst     = 1'b1;
      bus.m_cyc_i  = 1'b0;
      bus.m_stb_i  = 1'b0;
      bus.m_we_i   = 1'b0;
      bus.m_sel_i  = 4'h0;
      bus.m_adr_i  = '0;
      bus.m_dat_i  = '0;
      bus.s_ack_i  = 2'b00;
      bus.s_iena_i = 2'b11;
      bus.s_dat_i  = {32'hA5A5_0001, 32'h5555_0000};
      tick(); tick();
      chk("rst_busy", busy_o, 0);
      chk("rst_ack", bus.m_ack_o, 0);
      chk("rst_err", bus.m_err_o, 0);
      chk("rst_dat", bus.m_dat_o, 0);
      chk("rst_stb", bus.s_stb_o, 0);
      chk("rst_cyc", bus.s_cyc_o, 0);
      chk("rst_err_adr", err_adr_o, 0);
      core_rst = 1'b0;
      tick();

      // Read slave1, ack on second strobe cycle
      req(1'b0, 32'h3000_0010, 32'h0, 4'hF);
      tick();
      chk("rd_stb_c1", bus.s_stb_o, 2'b10);
      chk("rd_cyc_c1", bus.s_cyc_o, 2'b10);
      chk("rd_adr", bus.s_adr_o, 32'h3000_0010);
      chk("rd_busy", busy_o, 1);
      chk("rd_noack_c1", bus.m_ack_o, 0);
      tick();
      chk("rd_stb_c2", bus.s_stb_o, 2'b10);
      bus.s_ack_i = 2'b10;
      tick();
      chk("rd_ack_c3", bus.m_ack_o, 1);
      chk("rd_dat_c3", bus.m_dat_o, 32'hA5A5_0001);
      chk("rd_stb_off", bus.s_stb_o, 2'b00);
      chk("rd_no_err", bus.m_err_o, 0);
      drop();
      tick();
      chk("rd_ack_1cyc", bus.m_ack_o, 0);
      chk("rd_dat_idle", bus.m_dat_o, 0);
      chk("rd_idle", busy_o, 0);

      // Write slave0; request fields stay put even if master data wiggles
      req(1'b1, 32'h2600_0004, 32'h1234_5678, 4'b0011);
      tick();
      chk("wr_stb", bus.s_stb_o, 2'b01);
      chk("wr_dat", bus.s_dat_o, 32'h1234_5678);
      chk("wr_sel", bus.s_sel_o, 4'b0011);
      chk("wr_we", bus.s_we_o, 1);
      bus.m_dat_i = 32'hFFFF_0000;
      bus.s_dat_i = {32'hA5A5_0001, 32'hDEAD_BEEF};
      tick();
      chk("wr_dat_hold", bus.s_dat_o, 32'h1234_5678);
      chk("wr_sel_hold", bus.s_sel_o, 4'b0011);
      bus.s_ack_i = 2'b01;
      tick();
      chk("wr_ack", bus.m_ack_o, 1);
      chk("wr_rdat_zero", bus.m_dat_o, 0);
      drop();
      tick();

      // Unmapped address
      req(1'b0, 32'h4000_0000, 32'h0, 4'hF);
      tick();
      chk("um_err", bus.m_err_o, 1);
      chk("um_ack", bus.m_ack_o, 0);
      chk("um_stb", bus.s_stb_o, 2'b00);
      chk("um_dat", bus.m_dat_o, 32'hFFFF_FFFF);
      chk("um_err_adr", err_adr_o, 32'h4000_0000);
      drop();
      tick();
      chk("um_err_1cyc", bus.m_err_o, 0);
      chk("um_idle", busy_o, 0);
      chk("um_err_adr_keep", err_adr_o, 32'h4000_0000);

      // Disabled acks and wrong-channel ack are ignored
      bus.s_dat_i = {32'h0BAD_F00D, 32'h5555_0000};
      req(1'b0, 32'h3000_0020, 32'h0, 4'hF);
      tick();
      bus.s_ack_i  = 2'b10;
      bus.s_iena_i = 2'b01;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ie_no_ack", bus.m_ack_o, 0);
         chk("ie_stb_held", bus.s_stb_o, 2'b10);
      end
      bus.s_ack_i  = 2'b01;
      bus.s_iena_i = 2'b11;
      tick();
      chk("ie_wrong_ch", bus.m_ack_o, 0);
      bus.s_ack_i = 2'b10;
      tick();
      chk("ie_ack", bus.m_ack_o, 1);
      chk("ie_dat", bus.m_dat_o, 32'h0BAD_F00D);
      drop();
      tick();
      chk("ie_single_ack", bus.m_ack_o, 0);

      // Master abort in REQ
      req(1'b0, 32'h3000_0000, 32'h0, 4'hF);
      tick();
      chk("ab_stb", bus.s_stb_o, 2'b10);
      drop();
      tick();
      chk("ab_stb_off", bus.s_stb_o, 2'b00);
      chk("ab_busy", busy_o, 0);
      chk("ab_ack", bus.m_ack_o, 0);
      chk("ab_err", bus.m_err_o, 0);
      tick();
      chk("ab_no_late_ack", bus.m_ack_o | bus.m_err_o, 0);

      // Reset mid-REQ
      req(1'b0, 32'h2600_0000, 32'h0, 4'hF);
      tick();
      chk("rr_stb", bus.s_stb_o, 2'b01);
      core_rst = 1'b1;
      drop();
      tick();
      chk("rr_stb_off", bus.s_stb_o, 2'b00);
      chk("rr_busy", busy_o, 0);
      chk("rr_ack_err", {bus.m_ack_o, bus.m_err_o}, 2'b00);
      chk("rr_err_adr", err_adr_o, 0);
      chk("rr_s_adr", bus.s_adr_o, 0);
      core_rst = 1'b0;
      tick();

      // Slave never acks
      req(1'b0, 32'h3000_0040, 32'h0, 4'hF);
      tick();
      first_err = 0;
      for (int n = 1; n <= 300; n++) begin
         tick();
         if (n == 255) chk("to_stb_held", bus.s_stb_o, 2'b10);
         if (bus.m_err_o) begin
            first_err = n;
            chk("to_stb_off", bus.s_stb_o, 2'b00);
            chk("to_dat", bus.m_dat_o, 32'hFFFF_FFFF);
            chk("to_err_adr", err_adr_o, 32'h3000_0040);
            drop();
            break;
         end
      end
`ifdef MGMT_WB_SPLITTER_TIMEOUT_EN
      chk("to_latency", first_err, 256);
`else
      chk("hang_no_err", first_err, 0);
      chk("hang_busy", busy_o, 1);
      chk("hang_stb", bus.s_stb_o, 2'b10);
      drop();
`endif
      tick();
      chk("hang_idle", busy_o, 0);

      // Normal service afterwards, immediate ack
      bus.s_dat_i = {32'h0BAD_F00D, 32'h0000_CAFE};
      req(1'b0, 32'h2600_0100, 32'h0, 4'hF);
      tick();
      chk("nx_stb", bus.s_stb_o, 2'b01);
      bus.s_ack_i = 2'b01;
      tick();
      chk("nx_ack", bus.m_ack_o, 1);
      chk("nx_dat", bus.m_dat_o, 32'h0000_CAFE);
      drop();
      tick();
      chk("nx_idle", busy_o, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
